// File: rtl/uart_rx_frame_sampler.sv
// uart_rx_frame_sampler: oversampling UART receive front-end.
// Synchronises rx, detects start bits, samples each bit at mid-period,
// checks stop (and optional parity) bits and holds one completed frame
// on a valid/ready output port.
// Optional feature macro: UART_RX_FRAME_SAMPLER_PARITY_EN (adds a parity bit).
//
// Handshake: a frame transfers on any cycle where frame_valid && frame_ready.
// While frame_valid is high and frame_ready is low, frame_data and the error
// flags hold steady. A frame completing while the register is still full
// (and not being accepted) is dropped and signalled with a one-cycle overrun.
module uart_rx_frame_sampler #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DIV_WIDTH-1:0]  baud_div,
    input  logic                  odd_parity,
    input  logic                  rx,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic [DATA_WIDTH-1:0] frame_data,
    output logic                  parity_err,
    output logic                  framing_err,
    output logic                  overrun,
    output logic                  busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] HALF_M1  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);

`ifdef UART_RX_FRAME_SAMPLER_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t                state, state_next;
    logic                  rx_meta, rx_s;
    logic [DIV_WIDTH-1:0]  div_cnt, div_max;
    logic                  tick;
    logic                  armed;
    logic [CW-1:0]         samp_cnt;
    logic [IW-1:0]         bit_idx;
    logic [DATA_WIDTH-1:0] data_sr;
    logic                  par_err_pend;
    logic                  sample_hit;
    logic                  start_det;
    logic                  done;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // A divisor of zero behaves as one; >= keeps the counter bounded if baud_div shrinks mid-count.
    assign div_max = (baud_div == '0) ? DIV_WIDTH'(1) : baud_div;
    assign tick    = (div_cnt >= (div_max - DIV_WIDTH'(1)));

    // Oversample tick counter, realigned to the start edge.
    always_ff @(posedge clk) begin
        if (reset || start_det || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_WIDTH'(1);
        end
    end

    // Sample point: half a bit into the start bit, one full bit thereafter.
    assign sample_hit = tick && (samp_cnt == ((state == S_START) ? HALF_M1 : FULL_M1));

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and control strobes.
    always_comb begin
        state_next = state;
        start_det  = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (armed && !rx_s) begin
                    start_det  = 1'b1;
                    state_next = S_START;
                end
            end
            S_START: begin
                if (sample_hit) begin
                    state_next = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (sample_hit && (bit_idx == LAST_BIT)) begin
`ifdef UART_RX_FRAME_SAMPLER_PARITY_EN
                    state_next = S_PARITY;
`else
                    state_next = S_STOP;
`endif
                end
            end
`ifdef UART_RX_FRAME_SAMPLER_PARITY_EN
            S_PARITY: begin
                if (sample_hit) begin
                    state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (sample_hit) begin
                    done       = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Start qualifier: a line that stays low (break) must go high before the next start.
    always_ff @(posedge clk) begin
        if (reset || start_det) begin
            armed <= 1'b0;
        end else if (state == S_IDLE && rx_s) begin
            armed <= 1'b1;
        end else if (done) begin
            armed <= rx_s;
        end
    end

    // Tick counter within a bit period and data bit index.
    always_ff @(posedge clk) begin
        if (reset || state == S_IDLE || sample_hit) begin
            samp_cnt <= '0;
        end else if (tick) begin
            samp_cnt <= samp_cnt + CW'(1);
        end
        if (reset || state == S_START) begin
            bit_idx <= '0;
        end else if (state == S_DATA && sample_hit) begin
            bit_idx <= bit_idx + IW'(1);
        end
    end

    // Capture data bits, LSB first on the wire.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_sr <= '0;
        end else if (state == S_DATA && sample_hit) begin
            data_sr[bit_idx] <= rx_s;
        end
    end

`ifdef UART_RX_FRAME_SAMPLER_PARITY_EN
    // Parity check: total ones over data and parity bit must match the selected sense.
    always_ff @(posedge clk) begin
        if (reset || state == S_START) begin
            par_err_pend <= 1'b0;
        end else if (state == S_PARITY && sample_hit) begin
            par_err_pend <= ((^data_sr) ^ rx_s) != odd_parity;
        end
    end
`else
    assign par_err_pend = odd_parity & 1'b0;
`endif

    // Output holding register with overrun detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_valid <= 1'b0;
            frame_data  <= '0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done && (!frame_valid || frame_ready)) begin
                frame_valid <= 1'b1;
                frame_data  <= data_sr;
                parity_err  <= par_err_pend;
                framing_err <= !rx_s;
            end else begin
                if (done) begin
                    overrun <= 1'b1;
                end
                if (frame_valid && frame_ready) begin
                    frame_valid <= 1'b0;
                end
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_sampler.sv
// Bench for uart_rx_frame_sampler: table-driven frames plus hand-written
// sequences for latency, break, glitch, overrun and (when compiled in) parity.
module tb_uart_rx_frame_sampler;

  localparam int OS   = 16;
  localparam int DW   = 8;
  localparam int DIVW = 16;
`ifdef UART_RX_FRAME_SAMPLER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int EW = DW + 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [DIVW-1:0] baud_div = 16'd1;
  logic            odd_parity = 1'b0;
  logic            rx = 1'b1;
  logic            frame_valid;
  logic            frame_ready = 1'b1;
  logic [DW-1:0]   frame_data;
  logic            parity_err;
  logic            framing_err;
  logic            overrun;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int accept_cnt = 0;
  int ovr_cnt = 0;

  // {parity_err, framing_err, data}
  logic [EW-1:0] exp_q[$];

  typedef struct {
    logic [DW-1:0] data;
    logic          stop;
    int            bd;
    logic [DW-1:0] exp_data;
    logic          exp_fe;
  } vec_t;
  vec_t vecs[7];

  uart_rx_frame_sampler #(.OVERSAMPLE(OS), .DATA_WIDTH(DW), .DIV_WIDTH(DIVW)) dut (
    .clk(clk), .reset(reset), .baud_div(baud_div), .odd_parity(odd_parity),
    .rx(rx), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_data(frame_data), .parity_err(parity_err), .framing_err(framing_err),
    .overrun(overrun), .busy(busy)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Driver: one frame on rx, bit period = OS * max(bd,1) clocks.
  task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic stop, input int bd);
    int bc;
    bd_set(bd);
    bc = OS * ((bd == 0) ? 1 : bd);
    rx = 1'b0;
    wait_cycles(bc);
    for (int i = 0; i < DW; i++) begin
      rx = d[i];
      wait_cycles(bc);
    end
    if (PAR != 0) begin
      rx = p;
      wait_cycles(bc);
    end
    rx = stop;
    wait_cycles(bc);
    rx = 1'b1;
  endtask

  task automatic bd_set(input int bd);
    baud_div = DIVW'(bd);
  endtask

  // Correct parity bit for the current parity sense.
  function automatic logic good_par(input logic [DW-1:0] d);
    return (^d) ^ odd_parity;
  endfunction

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      wait_cycles(1);
      n++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Scoreboard: compare each accepted frame against the oldest expectation.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!reset) begin
      if (overrun) ovr_cnt++;
      if (frame_valid && frame_ready) begin
        accept_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("frame", int'({parity_err, framing_err, frame_data}), int'(e));
        end
      end
    end
  end

  initial begin
    int lat;
    int acc0;
    int ovr0;
    logic seen_busy;
    logic [DW-1:0] d;

    vecs[0] = '{8'hA5, 1'b1, 1, 8'hA5, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 2, 8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 0, 8'hFF, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 1, 8'h3C, 1'b1};
    vecs[4] = '{8'h81, 1'b1, 3, 8'h81, 1'b0};
    d = DW'($urandom_range(0, 255));
    vecs[5] = '{d, 1'b1, 1, d, 1'b0};
    d = DW'($urandom_range(0, 255));
    vecs[6] = '{d, 1'b0, 2, d, 1'b1};

    // Reset and idle
    wait_cycles(5);
    reset = 1'b0;
    check("reset_busy", busy, 0);
    check("reset_valid", frame_valid, 0);
    wait_cycles(100);
    check("idle_valid", frame_valid, 0);
    check("idle_data", frame_data, 0);
    check("idle_perr", parity_err, 0);
    check("idle_ferr", framing_err, 0);
    check("idle_overrun", overrun, 0);
    check("idle_busy", busy, 0);

    // Clean frame with latency from start edge to frame_valid
    exp_q.push_back({2'b00, 8'hA5});
    lat = -1;
    fork
      send_frame(8'hA5, good_par(8'hA5), 1'b1, 1);
      begin
        for (int n = 1; n <= 400; n++) begin
          wait_cycles(1);
          if (frame_valid) begin
            lat = n;
            break;
          end
        end
      end
    join
    check("valid_latency", lat, 3 + OS / 2 + (DW + 1 + PAR) * OS);
    wait_drain("drain_clean");
    wait_cycles(2 * OS);

    // Table-driven frames
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back({1'b0, vecs[i].exp_fe, vecs[i].exp_data});
      send_frame(vecs[i].data, good_par(vecs[i].data), vecs[i].stop, vecs[i].bd);
      wait_drain("drain_table");
      wait_cycles(2 * OS);
    end

    // Framing error followed by a break
    bd_set(1);
    acc0 = accept_cnt;
    exp_q.push_back({2'b01, 8'h3C});
    send_frame(8'h3C, good_par(8'h3C), 1'b0, 1);
    rx = 1'b0;
    wait_cycles(3 * (DW + 2 + PAR) * OS);
    check("break_frames", accept_cnt - acc0, 1);
    check("break_busy", busy, 0);
    check("break_valid", frame_valid, 0);
    rx = 1'b1;
    wait_cycles(2 * OS);
    check("after_break_frames", accept_cnt - acc0, 1);
    wait_drain("drain_break");

    // Glitch rejection
    acc0 = accept_cnt;
    seen_busy = 1'b0;
    rx = 1'b0;
    wait_cycles(4);
    rx = 1'b1;
    for (int n = 0; n < 40; n++) begin
      wait_cycles(1);
      if (busy) seen_busy = 1'b1;
    end
    check("glitch_seen_busy", seen_busy, 1);
    check("glitch_busy", busy, 0);
    check("glitch_valid", frame_valid, 0);
    check("glitch_frames", accept_cnt - acc0, 0);

    // Overrun: second frame dropped while the first is held
    frame_ready = 1'b0;
    acc0 = accept_cnt;
    ovr0 = ovr_cnt;
    exp_q.push_back({2'b00, 8'h11});
    send_frame(8'h11, good_par(8'h11), 1'b1, 1);
    send_frame(8'h22, good_par(8'h22), 1'b1, 1);
    wait_cycles(20);
    check("ovr_valid", frame_valid, 1);
    check("ovr_data", frame_data, 8'h11);
    check("ovr_pulses", ovr_cnt - ovr0, 1);
    check("ovr_frames", accept_cnt - acc0, 0);
    frame_ready = 1'b1;
    wait_drain("drain_overrun");
    wait_cycles(2);
    check("ovr_valid_drop", frame_valid, 0);
    check("ovr_accepted", accept_cnt - acc0, 1);

`ifdef UART_RX_FRAME_SAMPLER_PARITY_EN
    // Even parity: correct and corrupted parity bit
    odd_parity = 1'b0;
    wait_cycles(2 * OS);
    exp_q.push_back({2'b00, 8'h07});
    send_frame(8'h07, 1'b1, 1'b1, 1);
    wait_drain("drain_par_ok");
    wait_cycles(2 * OS);
    exp_q.push_back({2'b10, 8'h07});
    send_frame(8'h07, 1'b0, 1'b1, 1);
    wait_drain("drain_par_bad");
    wait_cycles(2 * OS);
    // Odd parity with a correct bit
    odd_parity = 1'b1;
    exp_q.push_back({2'b00, 8'h5A});
    send_frame(8'h5A, good_par(8'h5A), 1'b1, 2);
    wait_drain("drain_par_odd");
`endif

    wait_cycles(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_sampler.md
# uart_rx_frame_sampler

Synthesizable oversampling UART receive front-end that sits directly upstream of the slave monitor BFM. It synchronises the serial `rx` line, finds start bits, samples each bit at mid-period, checks stop (and optionally parity) bits, and presents one completed frame at a time on a valid/ready port. The slave monitor proxy consumes that port to build transactions.

## Interface
Parameters:
- `OVERSAMPLE`, 16: oversample ticks per bit; even, 8..32.
- `DATA_WIDTH`, 8: data bits per frame, 5..8.
- `DIV_WIDTH`, 16: width of `baud_div`.

Ports:
- `clk`  input  1  single clock; all logic on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `baud_div`  input  DIV_WIDTH  clk cycles per oversample tick; 0 is treated as 1. Sampled continuously.
- `odd_parity`  input  1  1 = odd, 0 = even. Used only with the parity feature.
- `rx`  input  1  asynchronous serial line; idle high.
- `frame_valid`  output  1  a frame is held in the output register.
- `frame_ready`  input  1  consumer accepts the frame.
- `frame_data`  output  DATA_WIDTH  received data, LSB = first bit on the wire.
- `parity_err`  output  1  parity mismatch for the held frame.
- `framing_err`  output  1  stop bit sampled low for the held frame.
- `overrun`  output  1  one-cycle pulse when a completed frame is dropped.
- `busy`  output  1  FSM is not in IDLE.

## Operation
- Two-flop synchroniser on `rx`, reset to 1. All decoding uses the synchronised value `rx_s`.
- Tick generator: counter runs 0..max(baud_div,1)-1. It produces a one-cycle `tick` on the terminal count and wraps to 0. The counter is cleared when IDLE detects a start.
- `armed` flag: set while `rx_s`=1 in IDLE. It is cleared on start detection, so a held-low line (break) never re-triggers.
- FSM states:
  - IDLE: when `armed` and `rx_s`=0, go to START and clear the tick counter.
  - START: after OVERSAMPLE/2 ticks, sample. If `rx_s`=1, the start was a glitch: return to IDLE with no output. Otherwise go to DATA with bit index 0.
  - DATA: every OVERSAMPLE ticks, shift `rx_s` into bit[index]. After DATA_WIDTH bits, go to PARITY if the feature is enabled, else STOP.
  - PARITY: after OVERSAMPLE ticks, sample the parity bit and compute the error: XOR of data and parity bit, compared against `odd_parity`. Go to STOP.
  - STOP: after OVERSAMPLE ticks, sample the stop bit; `framing_err`=!`rx_s`. Complete the frame and return to IDLE.
- Frame completion, in the cycle after the stop sample:
  - If the output register is empty, or is being accepted this cycle (`frame_valid && frame_ready`), load data and flags and assert `frame_valid`.
  - Otherwise drop the new frame, pulse `overrun`, and leave the held frame unchanged.
- A frame with a framing error is still delivered.
- Handshake: the transfer occurs when `frame_valid && frame_ready`. Outputs stay stable while `frame_valid && !frame_ready`. `frame_valid` deasserts the cycle after acceptance, unless it is reloaded in that same cycle.
- `baud_div` changed mid-frame: takes effect at the counter's next wrap; the frame is not protected.

## Timing
- Reset values: `frame_valid`=0, `frame_data`=0, `parity_err`=0, `framing_err`=0, `overrun`=0, `busy`=0. FSM=IDLE, `armed`=0, tick counter=0, synchroniser=1.
- Reset mid-frame: the partial frame is discarded and the held frame is lost. The block must see `rx_s`=1 before it accepts a new start.
- `rx` to `rx_s` latency: 2 cycles. `busy` rises 1 cycle after `rx_s` falls.
- Stop-bit sample tick number, counted from start detection: OVERSAMPLE/2 + (DATA_WIDTH+1+P)·OVERSAMPLE, where P=1 if parity is compiled in, else 0.
- `frame_valid` rises 1 cycle after the tick that samples the stop bit.
- Back-to-back frames: a start edge is accepted on the cycle after STOP returns to IDLE, provided `rx_s`=1 was seen during STOP's sample.

## Configuration
- Macro `UART_RX_FRAME_SAMPLER_PARITY_EN`.
- Defined: the PARITY state exists. `parity_err` is computed as described in Operation, and `odd_parity` is used.
- Undefined:
  - The frame has no parity bit; the FSM goes DATA→STOP.
  - `parity_err` is tied to 0.
  - `odd_parity` is ignored.

## Test plan
- Reset and idle: `baud_div`=1, `rx`=1 for 100 cycles → all outputs 0 and `busy`=0.
- Clean frame: `baud_div`=1, OVERSAMPLE=16, no parity, send 0xA5 with stop=1, `frame_ready`=1 → one `frame_valid` pulse with `frame_data`=0xA5, both error flags 0.
- Parity (macro defined), even parity:
  - Send 0x07 with parity bit 1 → `parity_err`=0.
  - Repeat with parity bit 0 → `parity_err`=1.
- Framing error and break: send 0x3C with stop=0, then hold `rx` low for 3 frame times → one frame, 0x3C with `framing_err`=1; no further frames until `rx` returns high.
- Glitch rejection: drive `rx` low for 4 cycles at `baud_div`=1 → `busy` returns to 0 and no `frame_valid`.
- Overrun:
  - `frame_ready`=0, send 0x11 then 0x22 → `frame_valid` holds 0x11 and `overrun` pulses once for one cycle.
  - Then raise `frame_ready` → 0x11 is accepted and `frame_valid` drops.
